// File: rtl/fetch_pkg.sv
// Shared types and helpers for the instruction fetch unit and its prefetch FIFO.
package fetch_pkg;

    localparam int INSTR_BYTES = 4;
    localparam int PC_W        = 64;
    localparam int INSTR_W     = 32;
    localparam int ENTRY_W     = PC_W + INSTR_W;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    typedef enum logic {
        FS_RUN   = 1'b0,
        FS_FAULT = 1'b1
    } fetch_state_t;

    // Widened by one bit so pc+3 near 2^64 cannot wrap back into range.
    function automatic logic addr_bad(input logic [63:0] pc, input logic [64:0] mem_size);
        logic [64:0] last_byte;
        last_byte = {1'b0, pc} + 65'(INSTR_BYTES - 1);
        return (pc[1:0] != 2'b00) || (last_byte >= mem_size);
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO of {pc, instr} entries; wrap-bit pointers, flush has priority over push/pop.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               push,
    input  logic               pop,
    input  logic               flush,
    input  logic [ENTRY_W-1:0] wr_data,
    output logic [ENTRY_W-1:0] head,
    output logic               empty,
    output logic               full
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]        wr_ptr;
    logic [AW:0]        rd_ptr;
    logic [ENTRY_W-1:0] mem [DEPTH];
    logic               wr_en;
    logic               rd_en;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    // A write into a full FIFO is legal only when the head leaves in the same cycle.
    assign wr_en = push && (!full || pop) && !flush;
    assign rd_en = pop && !empty && !flush;

    assign head = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + (AW+1)'(1);
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr[AW-1:0]] <= wr_data;
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch sequencer: drives the ROM address from fetch_pc, queues {pc, instr} for decode,
// handles redirects and raises a sticky fault on misaligned or out-of-range fetch addresses.
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter int          MEM_SIZE = 1024,
    parameter int          DEPTH    = 4,
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic [63:0] imem_addr,
    input  logic [31:0] imem_instr,
    output logic [31:0] instr,
    output logic [63:0] instr_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic        fault,
    output logic [63:0] fault_pc
);

    fetch_state_t       state;
    fetch_state_t       state_nxt;
    logic [63:0]        fetch_pc;
    logic [63:0]        fetch_pc_nxt;
    logic [63:0]        fault_pc_q;
    logic [63:0]        fault_pc_nxt;
    logic               bad;
    logic               push;
    logic               pop;
    logic               fifo_empty;
    logic               fifo_full;
    fetch_entry_t       wr_entry;
    fetch_entry_t       head_entry;
    logic [ENTRY_W-1:0] head_bits;

    assign bad = addr_bad(fetch_pc, 65'(MEM_SIZE));

    assign instr_valid = !fifo_empty;
    assign pop  = instr_valid && instr_ready && !redirect_valid;
    assign push = (state == FS_RUN) && !bad && !redirect_valid && (!fifo_full || pop);

    assign wr_entry   = '{pc: fetch_pc, instr: imem_instr};
    assign head_entry = head_bits;

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (push),
        .pop     (pop),
        .flush   (redirect_valid),
        .wr_data (wr_entry),
        .head    (head_bits),
        .empty   (fifo_empty),
        .full    (fifo_full)
    );

    always_comb begin
        state_nxt    = state;
        fetch_pc_nxt = fetch_pc;
        fault_pc_nxt = fault_pc_q;
        if (redirect_valid) begin
            state_nxt    = FS_RUN;
            fetch_pc_nxt = redirect_pc;
        end else begin
            case (state)
                FS_RUN: begin
                    if (bad) begin
                        state_nxt    = FS_FAULT;
                        fault_pc_nxt = fetch_pc;
                    end else if (push) begin
                        fetch_pc_nxt = fetch_pc + 64'(INSTR_BYTES);
                    end
                end
                FS_FAULT: begin
                    state_nxt = FS_FAULT;
                end
                default: begin
                    state_nxt = FS_RUN;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= FS_RUN;
            fetch_pc   <= RESET_PC;
            fault_pc_q <= '0;
        end else begin
            state      <= state_nxt;
            fetch_pc   <= fetch_pc_nxt;
            fault_pc_q <= fault_pc_nxt;
        end
    end

    assign imem_addr = fetch_pc;
    assign instr     = head_entry.instr;
    assign instr_pc  = head_entry.pc;
    assign fault     = (state == FS_FAULT);
    assign fault_pc  = fault_pc_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a ROM model and an in-order delivery scoreboard.
module tb_instr_fetch_unit;

    logic        clk;
    logic        reset_n;
    logic [63:0] imem_addr;
    logic [31:0] imem_instr;
    logic [31:0] instr;
    logic [63:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        fault;
    logic [63:0] fault_pc;

    int tests = 0;
    int fails = 0;
    int pops  = 0;
    logic [95:0] sb [$];

    instr_fetch_unit #(
        .MEM_SIZE (1024),
        .DEPTH    (4),
        .RESET_PC (64'h0)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .imem_addr      (imem_addr),
        .imem_instr     (imem_instr),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .fault          (fault),
        .fault_pc       (fault_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] rom(input logic [63:0] a);
        if (a < 64'd1024 && a[1:0] == 2'b00) return 32'hCAFE0000 ^ 32'(a >> 2);
        return 32'hxxxxxxxx;
    endfunction

    assign imem_instr = rom(imem_addr);

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic sb_seq(input logic [63:0] start, input int n);
        logic [63:0] a;
        for (int i = 0; i < n; i++) begin
            a = start + 64'(4 * i);
            sb.push_back({a, rom(a)});
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Scoreboard: every accepted handshake must match the next expected {pc, instr}.
    always @(negedge clk) begin
        logic [95:0] e;
        if (reset_n && instr_valid && instr_ready && !redirect_valid) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $error("FAIL sb_unexpected: observed pc %h, expected no delivery", instr_pc);
            end else begin
                e = sb.pop_front();
                check("sb_pc", instr_pc, e[95:32]);
                check("sb_instr", 64'(instr), 64'(e[31:0]));
                pops++;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int p0;
        logic seen;

        reset_n        = 1'b0;
        instr_ready    = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 64'h0;
        tick(3);
        check("rst_valid", 64'(instr_valid), 64'd0);
        check("rst_fault", 64'(fault), 64'd0);
        check("rst_fault_pc", fault_pc, 64'd0);
        check("rst_addr", imem_addr, 64'd0);

        // Stall out of reset: FIFO fills to DEPTH and the address freezes at 16.
        reset_n = 1'b1;
        sb_seq(64'h0, 64);
        check("pre_first_valid", 64'(instr_valid), 64'd0);
        tick(1);
        check("first_valid", 64'(instr_valid), 64'd1);
        check("first_pc", instr_pc, 64'd0);
        check("first_instr", 64'(instr), 64'(rom(64'd0)));
        tick(9);
        check("stall_addr", imem_addr, 64'd16);
        check("stall_head", instr_pc, 64'd0);
        instr_ready = 1'b1;
        p0 = pops;
        repeat (12) begin
            @(negedge clk);
            check("stream_valid", 64'(instr_valid), 64'd1);
        end
        tick(1);
        check("stream_count", 64'(pops - p0), 64'd12);

        // Redirect with a full FIFO and decode ready: flush, then 0x40 two cycles later.
        instr_ready = 1'b0;
        tick(6);
        check("full_before_redir", 64'(instr_valid), 64'd1);
        redirect_valid = 1'b1;
        redirect_pc    = 64'h40;
        instr_ready    = 1'b1;
        sb.delete();
        sb_seq(64'h40, 32);
        tick(1);
        redirect_valid = 1'b0;
        check("redir_flush", 64'(instr_valid), 64'd0);
        check("redir_addr", imem_addr, 64'h40);
        tick(1);
        check("redir_valid", 64'(instr_valid), 64'd1);
        check("redir_pc", instr_pc, 64'h40);
        p0 = pops;
        tick(8);
        check("redir_stream_count", 64'(pops - p0), 64'd8);

        // Run off the end of the ROM with a full FIFO: 1020 delivered, fault at 1024.
        redirect_valid = 1'b1;
        redirect_pc    = 64'd1000;
        instr_ready    = 1'b0;
        sb.delete();
        sb_seq(64'd1000, 6);
        tick(1);
        redirect_valid = 1'b0;
        tick(8);
        check("end_nofault", 64'(fault), 64'd0);
        check("end_stall_addr", imem_addr, 64'd1016);
        instr_ready = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            tick(1);
            if (fault) seen = 1'b1;
        end
        check("end_fault_seen", 64'(seen), 64'd1);
        check("end_drain_pending", 64'(instr_valid), 64'd1);
        check("end_fault_pc", fault_pc, 64'd1024);
        for (int i = 0; i < 20 && instr_valid; i++) tick(1);
        check("end_drained", 64'(sb.size()), 64'd0);
        check("end_addr_hold", imem_addr, 64'd1024);
        tick(3);
        check("end_no_more_valid", 64'(instr_valid), 64'd0);
        check("end_fault_sticky", 64'(fault), 64'd1);

        // Redirect to a misaligned target, then recover with a redirect to 0.
        redirect_valid = 1'b1;
        redirect_pc    = 64'h6;
        sb.delete();
        tick(1);
        redirect_valid = 1'b0;
        check("mis_fault_cleared", 64'(fault), 64'd0);
        check("mis_addr", imem_addr, 64'h6);
        tick(1);
        check("mis_fault", 64'(fault), 64'd1);
        check("mis_fault_pc", fault_pc, 64'h6);
        check("mis_no_push", 64'(instr_valid), 64'd0);
        tick(3);
        check("mis_still_empty", 64'(instr_valid), 64'd0);
        redirect_valid = 1'b1;
        redirect_pc    = 64'h0;
        sb_seq(64'h0, 64);
        tick(1);
        redirect_valid = 1'b0;
        check("recover_fault", 64'(fault), 64'd0);
        tick(1);
        check("recover_valid", 64'(instr_valid), 64'd1);
        check("recover_pc", instr_pc, 64'h0);
        p0 = pops;
        tick(5);
        check("recover_count", 64'(pops - p0), 64'd5);

        // Asynchronous reset mid-stream with a full FIFO.
        instr_ready = 1'b0;
        tick(6);
        check("prerst_head", instr_pc, 64'd20);
        check("prerst_addr", imem_addr, 64'd36);
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_valid", 64'(instr_valid), 64'd0);
        check("arst_fault_pc", fault_pc, 64'd0);
        check("arst_addr", imem_addr, 64'd0);
        check("arst_fault", 64'(fault), 64'd0);
        sb.delete();
        tick(1);
        reset_n     = 1'b1;
        instr_ready = 1'b1;
        sb_seq(64'h0, 64);
        tick(1);
        check("rerun_valid", 64'(instr_valid), 64'd1);
        check("rerun_pc", instr_pc, 64'h0);
        p0 = pops;
        tick(6);
        check("rerun_count", 64'(pops - p0), 64'd6);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
